// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL reset, qualifies the (asynchronous) PLL locked
//   signal, and releases the downstream system reset once lock has been stable.
// Latency: pll_locked rise -> ready/sys_rst release in 3+LOCK_STABLE_CYCLES
//   refclk cycles; lock loss in RUN drops ready 3 cycles after pll_locked falls.
// Backpressure: none; relock_req is a one-cycle request that is always accepted
//   and overrides every other transition.
// Build option: define PLL_SEQ_AUTO_RELOCK_EN to restart the sequence on lock
//   loss in RUN; left undefined, lock loss parks the block in FAULT.
// Ports:
//   refclk          in   free-running reference clock (only clock)
//   rst             in   asynchronous active-high reset
//   pll_locked      in   PLL locked, asynchronous to refclk
//   relock_req      in   one-cycle request to restart the sequence
//   pll_rst         out  PLL reset, active high
//   sys_rst         out  downstream reset, active high (low only in RUN)
//   ready           out  high only in RUN
//   fault           out  high only in FAULT
//   retry_count     out  failed lock attempts in the current sequence
//   lock_loss_count out  lock losses seen in RUN, saturating at 255
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 5000,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  // Counter terminal values: each state leaves on the cycle its counter
  // reaches N-1, so the state occupies exactly N cycles.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  // 2-FF synchronizer for the asynchronous locked input.
  logic sync_q;
  logic lk;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      lk     <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lk     <= sync_q;
    end
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       retry_d;
  logic [7:0]       loss_d;
  logic             pll_rst_d, sys_rst_d, ready_d, fault_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_count;
    loss_d  = lock_loss_count;

    if (relock_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_count < RETRY_MAX) begin
              retry_d = retry_count + 4'd1;
              state_d = S_RESET_PLL;
            end else begin
              state_d = S_FAULT;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // Any low cycle restarts qualification; retries are not charged.
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lk) begin
            if (lock_loss_count != 8'hFF) begin
              loss_d = lock_loss_count + 8'd1;
            end
            cnt_d = '0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            state_d = S_RESET_PLL;
`else
            state_d = S_FAULT;
`endif
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered, so they switch
    // on the same edge as the state itself.
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= S_RESET_PLL;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
      pll_rst         <= pll_rst_d;
      sys_rst         <= sys_rst_d;
      ready           <= ready_d;
      fault           <= fault_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: self-checking bench for pll_lock_sequencer.
// Output vectors are packed as {pll_rst, sys_rst, ready, fault,
// retry_count[3:0], lock_loss_count[7:0]}.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  bit clk_en = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST),
    .MAX_RETRIES        (MR),
    .CNT_W              (16)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .relock_req     (relock_req),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial begin
    refclk = 1'b0;
    forever #5 if (clk_en) refclk = ~refclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  // Phase plus "cycles spent in this phase"; the synchronizer is a 2-deep
  // history of sampled pll_locked values.
  typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} mphase_t;
  mphase_t m_phase;
  int      m_age;
  int      m_retries;
  int      m_losses;
  bit      m_hist [2];

  function automatic void model_reset();
    m_phase   = M_RESET;
    m_age     = 0;
    m_retries = 0;
    m_losses  = 0;
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
  endfunction

  function automatic void model_step(input bit locked_in, input bit req);
    bit lk_seen;
    lk_seen   = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = locked_in;
    if (req) begin
      m_phase   = M_RESET;
      m_age     = 0;
      m_retries = 0;
      return;
    end
    case (m_phase)
      M_RESET: begin
        m_age++;
        if (m_age == RP) begin m_phase = M_WAIT; m_age = 0; end
      end
      M_WAIT: begin
        if (lk_seen) begin
          m_phase = M_STABLE; m_age = 0;
        end else begin
          m_age++;
          if (m_age == TO) begin
            m_age = 0;
            if (m_retries < MR) begin m_retries++; m_phase = M_RESET; end
            else m_phase = M_FAULT;
          end
        end
      end
      M_STABLE: begin
        if (!lk_seen) begin
          m_phase = M_WAIT; m_age = 0;
        end else begin
          m_age++;
          if (m_age == ST) begin m_phase = M_RUN; m_age = 0; m_retries = 0; end
        end
      end
      M_RUN: begin
        if (!lk_seen) begin
          m_losses = (m_losses < 255) ? m_losses + 1 : 255;
          m_age    = 0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
          m_phase = M_RESET;
`else
          m_phase = M_FAULT;
`endif
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] mk_outs(input bit pr, input bit sr, input bit rd,
                                          input bit ft, input int rc, input int llc);
    return {pr, sr, rd, ft, 4'(rc), 8'(llc)};
  endfunction

  function automatic logic [15:0] model_outs();
    return mk_outs((m_phase == M_RESET) || (m_phase == M_FAULT), m_phase != M_RUN,
                   m_phase == M_RUN, m_phase == M_FAULT, m_retries, m_losses);
  endfunction

  function automatic logic [15:0] dut_outs();
    return {pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count};
  endfunction

  localparam logic [15:0] RESET_OUTS = 16'hC000;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset();
    else model_step(pll_locked, relock_req);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    check("reset_values", dut_outs(), RESET_OUTS);
    rst = 1'b0;
  endtask

  // Cycles until pll_rst is seen low (bounded).
  task automatic measure_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_rst === 1'b1 && n < 50);
  endtask

  task automatic wait_ready(input bit want, input int limit, output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < limit) begin
      tick();
      k++;
      if (ready === want) ok = 1'b1;
    end
  endtask

  typedef struct {
    bit          locked;
    bit          relock;
    int          cycles;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit l, input bit r, input int n, input bit pr,
                              input bit sr, input bit rd, input bit ft, input int rc);
    vec_t v;
    v.locked = l;
    v.relock = r;
    v.cycles = n;
    v.exp    = mk_outs(pr, sr, rd, ft, rc, 0);
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t vecs[$];
    int   n;
    int   fails;
    bit   ok;

    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    model_reset();

    // Normal start, relock, three timed-out attempts into FAULT, recovery.
    vecs.push_back(mk(0, 0,  3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 0));  // pll_rst was high 4 cycles
    vecs.push_back(mk(0, 0,  5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0));  // not yet released
    vecs.push_back(mk(1, 0,  1, 0, 0, 1, 0, 0));  // released 11 cycles after lock
    vecs.push_back(mk(0, 1,  1, 1, 1, 0, 0, 0));  // relock_req
    vecs.push_back(mk(0, 0,  3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 19, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, 1, 0, 0, 1));  // first timeout
    vecs.push_back(mk(0, 0,  3, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 19, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0,  1, 1, 1, 0, 0, 2));  // second timeout
    vecs.push_back(mk(0, 0,  3, 1, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0,  1, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 19, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0,  1, 1, 1, 0, 1, 2));  // FAULT
    vecs.push_back(mk(0, 0, 10, 1, 1, 0, 1, 2));  // held
    vecs.push_back(mk(0, 1,  1, 1, 1, 0, 0, 0));  // relock clears fault/retries
    vecs.push_back(mk(1, 0,  3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  8, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  1, 0, 0, 1, 0, 0));

    do_reset();
    foreach (vecs[i]) begin
      pll_locked = vecs[i].locked;
      relock_req = vecs[i].relock;
      repeat (vecs[i].cycles) tick();
      relock_req = 1'b0;
      check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
    end

    // One-cycle glitch on pll_locked during STABLE.
    pll_locked = 1'b1;
    do_reset();
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ok = 1'b0;
    repeat (10) begin
      tick();
      if (ready !== 1'b0) ok = 1'b1;
    end
    check("glitch_ready_held_low", 16'(ok), 16'd0);
    tick();
    check("glitch_release", dut_outs(), mk_outs(0, 0, 1, 0, 0, 0));

    // Lock loss in RUN.
    repeat (2) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    check("loss_ready_still_high", dut_outs(), mk_outs(0, 0, 1, 0, 0, 0));
    tick();
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    check("loss_response", dut_outs(), mk_outs(1, 1, 0, 0, 0, 1));
    measure_pulse(n);
    check("loss_pll_rst_width", 16'(n), 16'd4);
`else
    check("loss_response", dut_outs(), mk_outs(1, 1, 0, 1, 0, 1));
    repeat (5) tick();
    check("loss_fault_held", dut_outs(), mk_outs(1, 1, 0, 1, 0, 1));
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("loss_relock", dut_outs(), mk_outs(1, 1, 0, 0, 0, 1));
    measure_pulse(n);
    check("relock_pll_rst_width", 16'(n), 16'd4);
`endif

    // Drive enough lock losses to saturate lock_loss_count.
    fails = 0;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b1;
      if (fault === 1'b1) begin
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
      end
      wait_ready(1'b1, 60, ok);
      if (!ok) fails++;
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, ok);
      if (!ok) fails++;
    end
    check("sat_wait_timeouts", 16'(fails), 16'd0);
    check("sat_count", 16'(lock_loss_count), 16'd255);
    check("sat_vs_model", dut_outs(), model_outs());

    // Async reset mid-WAIT_LOCK with refclk stopped.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    repeat (6) tick();
    check("pre_stop_wait_lock", dut_outs(), mk_outs(0, 1, 0, 0, 0, 255));
    clk_en = 1'b0;
    #23;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_no_clock", dut_outs(), RESET_OUTS);
    #10;
    rst = 1'b0;
    #7;
    clk_en = 1'b1;
    measure_pulse(n);
    check("post_rst_pll_rst_width", 16'(n), 16'd4);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) pll_locked = ~pll_locked;
      relock_req = ($urandom_range(0, 149) == 0);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rand_async_rst", dut_outs(), model_outs());
      end
      tick();
      check($sformatf("rand_cycle%0d", i), dut_outs(), model_outs());
    end
    relock_req = 1'b0;
    rst        = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Supervises a general-purpose PLL instance: drives the PLL reset, qualifies its `locked` output, and releases a downstream system reset only after lock has been stable for a programmable time. It sits beside the PLL wrapper, clocked from the same free-running reference clock. It owns retry on lock timeout, reaction to loss of lock, and a fault flag for software.

## Interface
- `RST_PULSE_CYCLES`, 10: refclk cycles `pll_rst` is held high per reset attempt (≥1)
- `LOCK_TIMEOUT_CYCLES`, 5000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 5 MHz)
- `LOCK_STABLE_CYCLES`, 64: consecutive synchronized-locked cycles required before release (≥1)
- `MAX_RETRIES`, 3: failed attempts allowed after the first before FAULT (0–15)
- `CNT_W`, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters

- `refclk`  in  1  free-running reference clock; the only clock
- `rst`  in  1  asynchronous, active-high reset
- `pll_locked`  in  1  PLL `locked`, asynchronous to refclk
- `relock_req`  in  1  synchronous one-cycle request to restart the sequence
- `pll_rst`  out  1  PLL reset, active high
- `sys_rst`  out  1  downstream reset, active high
- `ready`  out  1  high only in RUN
- `fault`  out  1  high only in FAULT
- `retry_count`  out  4  failed attempts in the current sequence
- `lock_loss_count`  out  8  lock losses seen in RUN, saturating at 255

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `lk`. All outputs are registered.
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_count`=0, `lock_loss_count`=0, state RESET_PLL, counter 0.
- States and behaviour:
  - **RESET_PLL**: `pll_rst`=1. After exactly RST_PULSE_CYCLES cycles, go to WAIT_LOCK with the counter cleared.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `lk`=1: go to STABLE with the counter cleared.
    - Counter reaches LOCK_TIMEOUT_CYCLES-1 with `lk`=0 and `retry_count`<MAX_RETRIES: increment `retry_count` and go to RESET_PLL.
    - Same timeout with `retry_count`=MAX_RETRIES: go to FAULT.
  - **STABLE**:
    - `lk`=0: go to WAIT_LOCK with the counter cleared; `retry_count` is unchanged.
    - LOCK_STABLE_CYCLES consecutive cycles with `lk`=1: go to RUN.
  - **RUN**: `sys_rst`=0, `ready`=1, and `retry_count` clears on entry.
    - `lk`=0: increment `lock_loss_count` (saturating) and go to the lock-loss target state (see Configuration).
  - **FAULT**: `pll_rst`=1, `sys_rst`=1, `fault`=1. The state is held until `relock_req` or `rst`.
- `relock_req` has priority over every other transition in every state. It moves the state to RESET_PLL and clears `retry_count`, `fault` and the counter. `lock_loss_count` is not cleared.
- `sys_rst` is 1 in every state except RUN.

## Timing
- The `pll_rst` pulse is exactly RST_PULSE_CYCLES cycles wide.
- Lock-to-release latency:
  - `pll_locked` rising to `lk` rising: 2 cycles.
  - `ready`/`sys_rst` change on the edge LOCK_STABLE_CYCLES+1 cycles after `lk` first seen.
  - Total: 3+LOCK_STABLE_CYCLES cycles from `pll_locked` rising.
- Lock loss in RUN: `ready`=0 and `sys_rst`=1 on the edge following `lk` falling, which is 3 cycles after `pll_locked` falls.
- A `relock_req` sampled on edge N gives `pll_rst`=1 from edge N.
- Async `rst` forces reset values immediately, with no clock edge, including mid-operation.

## Configuration
- `PLL_SEQ_AUTO_RELOCK_EN` defined: lock loss in RUN goes to RESET_PLL and the sequence restarts automatically with `retry_count`=0.
- Not defined: lock loss in RUN goes to FAULT, and only `relock_req` or `rst` recovers.
- `lock_loss_count` behaves the same in both builds.

## Test plan
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal start, `pll_locked` rises 5 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles; `ready`=1 and `sys_rst`=0 exactly 11 cycles after `pll_locked` rises; `retry_count`=0.
2. `pll_locked` held 0 -> three 4-cycle `pll_rst` pulses, each followed by 20 WAIT_LOCK cycles; `retry_count` goes 1, 2; then `fault`=1, `pll_rst`=1, `sys_rst`=1.
3. 1-cycle low glitch on `pll_locked` during STABLE -> state returns to WAIT_LOCK and `ready` stays 0; `ready` rises 11 cycles after the glitch ends; `retry_count` unchanged.
4. `pll_locked` drops in RUN:
   - Macro defined: `sys_rst`=1 and `ready`=0 3 cycles later, `lock_loss_count`=1, then a 4-cycle `pll_rst` pulse.
   - Macro undefined: same `sys_rst`/`ready` response, then `fault`=1.
5. `relock_req` pulse in FAULT -> next cycle `fault`=0 and `retry_count`=0; `pll_rst` high 4 cycles; normal lock then gives `ready`=1.
6. `rst` asserted mid-WAIT_LOCK with `refclk` stopped -> all outputs take reset values immediately; on release the sequence restarts with a 4-cycle `pll_rst` pulse.
